branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised next-generation branch comparator for the pipelined MIPS core. It sits at the EX-stage boundary.
- Evaluates an extended set of branch conditions on operands of configurable width through one registered stage, with a valid/ready handshake.
- Compares the outcome against the fetch-time prediction and issues the redirect PC.
- Owns a per-PC 2-bit saturating branch history table (BHT), which fetch reads and resolution updates.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
DATA_W, 32, operand width in bits (>=2)
PC_W, 32, program counter width
BHT_DEPTH, 64, number of BHT entries; power of two, >=2; IDX_W = log2(BHT_DEPTH)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
lookup_pc  in  PC_W  fetch-stage PC for prediction
lookup_taken  out  1  predicted taken, combinational = bht[idx(lookup_pc)][1]
in_valid  in  1  branch op presented
in_ready  out  1  unit can accept
in_ctrl  in  4  condition code, see Behaviour
in_a  in  DATA_W  operand rs
in_b  in  DATA_W  operand rt
in_pc  in  PC_W  branch instruction PC
in_target  in  PC_W  taken-target PC
in_pred_taken  in  1  prediction carried down the pipe
flush  in  1  discard pending and incoming op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_taken  out  1  resolved direction
out_mispredict  out  1  out_taken != registered pred_taken
out_redirect_pc  out  PC_W  out_taken ? target : pc+4 (mod 2^PC_W)
perf_branches  out  CNT_W  resolved branch count
perf_mispred  out  CNT_W  mispredict count

Behaviour:
- Ctrl codes:
  - 0 none: not taken.
  - 1 beq: a==b.
  - 2 bne: a!=b.
  - 3 blez: a signed <=0.
  - 4 bgtz: a signed >0.
  - 5 blt: a<b signed.
  - 6 bgez: a signed >=0.
  - 7 bltu: a<b unsigned.
  - 8 bgeu: a>=b unsigned.
  - 9-15: reserved; treated as 0.
- Codes 0 and 9-15 are "non-branch": they pass through the stage, never update the BHT or the counters, and force out_mispredict=0.
- Signed compares use bit DATA_W-1 as the sign.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready && !flush.
  - The stage register loads on accept; latency is 1 cycle, giving a throughput of 1 op/cycle.
  - out_* hold stable while out_valid && !out_ready.
- out_valid next-state:
  - flush → 0.
  - else accept → 1.
  - else out_ready → 0.
  - else hold.
- Flush: the pending result is dropped without a BHT or counter update. A same-cycle in_valid is dropped too.
- Commit: on out_valid && out_ready && !flush, for a real branch:
  - BHT entry idx(pc) increments on taken and decrements on not taken, saturating at 3 and 0.
  - perf_branches += 1, saturating at all-ones.
  - If mispredicted, perf_mispred += 1, saturating.
- idx(pc) = pc[IDX_W+1:2].
- Same-cycle lookup of an entry being committed returns the pre-update value. No bypass.
- Reset (rst_n=0 at a clock edge), takes effect at that edge even mid-operation:
  - out_valid=0, out_taken=0, out_mispredict=0, out_redirect_pc=0.
  - All BHT entries = 2'b01 (weakly not taken).
  - Both counters = 0.
  - in_ready=1 after reset.
- Reset wins over flush and accept.

Decomposition:
- Shared package, branch_pkg: the ctrl code constants (BR_NONE, BR_BEQ … BR_BGEU), the counter states SNT/WNT/WT/ST, and the BHT reset value.
- One sub-module is natural: branch_cond_eval. It is the purely combinational DATA_W-parametrised condition evaluator, reused by the ID-stage early-branch path.
- The BHT array, pipeline register and counters stay in the top module.

Test Plan:
1. Reset, then lookup_pc=0x0000_0040 → lookup_taken=0. in_ctrl=1 (beq), a=b=5, pred=0, pc=0x40, target=0x100 → next cycle out_taken=1, mispredict=1, redirect=0x100. After commit, perf_branches=1, perf_mispred=1, and bht[16]=2'b10 so lookup_taken=1.
2. Signedness: ctrl=5 with a=0xFFFF_FFFF, b=1 → taken. ctrl=7 with the same operands → not taken, redirect=pc+4. ctrl=3 with a=0 → taken; ctrl=4 with a=0 → not taken.
3. Backpressure: out_ready=0 for 3 cycles with a second op waiting. Required: in_ready=0, outputs stable and no BHT change until out_ready=1. The second op then appears the next cycle.
4. Flush with out_valid=1 and in_valid=1 in the same cycle → out_valid=0 next cycle; counters and BHT unchanged.
5. Saturation: 4 taken commits to one PC → entry=3, a 5th taken commit leaves it 3. With CNT_W=2, 5 branches → perf_branches=3.
6. Reserved code: ctrl=12 with pred=1 → out_taken=0, mispredict=0, redirect=pc+4, no counter change. rst_n=0 mid-stall → out_valid=0 and the BHT returns to 01.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution path: condition codes,
// 2-bit history counter states and the history table reset value.
package branch_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLT  = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_BLTU = 4'd7;
  localparam logic [3:0] BR_BGEU = 4'd8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RST = WNT;

  // Codes above BR_BGEU are reserved and behave like BR_NONE.
  function automatic logic is_branch_code(input logic [3:0] code);
    return (code != BR_NONE) && (code <= BR_BGEU);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; shared with the ID-stage
// early-branch path, so it holds no state.
module branch_cond_eval #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken,
  output logic              is_branch
);
  import branch_pkg::*;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     a_zero;

  assign a_s    = a;
  assign b_s    = b;
  assign a_zero = (a == '0);

  always_comb begin
    taken     = 1'b0;
    is_branch = is_branch_code(ctrl);
    case (ctrl)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLEZ: taken = a_s[DATA_W-1] || a_zero;
      BR_BGTZ: taken = !a_s[DATA_W-1] && !a_zero;
      BR_BLT:  taken = (a_s < b_s);
      BR_BGEZ: taken = !a_s[DATA_W-1];
      BR_BLTU: taken = (a < b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: one registered compare stage with valid/ready,
// mispredict/redirect generation, 2-bit BHT and saturating perf counters.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_taken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_target,
  input  logic              in_pred_taken,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [PC_W-1:0]   out_redirect_pc,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_mispred
);
  import branch_pkg::*;

  localparam int IDX_W = $clog2(BHT_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
    bht_state_e n;
    n = s;
    if (taken) begin
      case (s)
        SNT:     n = WNT;
        WNT:     n = WT;
        default: n = ST;
      endcase
    end else begin
      case (s)
        ST:      n = WT;
        WT:      n = WNT;
        default: n = SNT;
      endcase
    end
    return n;
  endfunction

  bht_state_e        bht [BHT_DEPTH];
  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  idx_p0;
  logic              taken_p0;
  logic              br_p0;
  logic              accept;
  logic              commit;
  logic              unused_lookup_bits;

  logic              vld_p1;
  logic              br_p1;
  logic              taken_p1;
  logic              mispred_p1;
  logic [PC_W-1:0]   redirect_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [CNT_W-1:0]  branches_q;
  logic [CNT_W-1:0]  mispred_q;

  assign lookup_idx         = lookup_pc[IDX_W+1:2];
  assign idx_p0             = in_pc[IDX_W+1:2];
  assign unused_lookup_bits = ^lookup_pc;
  // Read of the pre-commit table contents; an entry committing this cycle is not bypassed.
  assign lookup_taken       = bht[lookup_idx][1];

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign commit   = vld_p1 && out_ready && !flush && br_p1;

  // Stage p0: condition evaluation on the incoming operands
  branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .ctrl      (in_ctrl),
    .a         (in_a),
    .b         (in_b),
    .taken     (taken_p0),
    .is_branch (br_p0)
  );

  // Stage p1: result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      br_p1       <= 1'b0;
      taken_p1    <= 1'b0;
      mispred_p1  <= 1'b0;
      redirect_p1 <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept)    vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        br_p1       <= br_p0;
        taken_p1    <= taken_p0;
        mispred_p1  <= br_p0 && (taken_p0 != in_pred_taken);
        redirect_p1 <= taken_p0 ? in_target : in_pc + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) idx_p1 <= idx_p0;
  end

  // Commit: history and counters advance only when a real branch leaves the stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_RST;
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (commit) begin
      bht[idx_p1] <= bht_next(bht[idx_p1], taken_p1);
      branches_q  <= sat_inc(branches_q);
      if (mispred_p1) mispred_q <= sat_inc(mispred_q);
    end
  end

  assign out_valid       = vld_p1;
  assign out_taken       = taken_p1;
  assign out_mispredict  = mispred_p1;
  assign out_redirect_pc = redirect_p1;
  assign perf_branches   = branches_q;
  assign perf_mispred    = mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then random
// traffic, checked against an arithmetic reference model.
module tb_branch_resolve_unit;

  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int BHT_DEPTH = 64;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam longint P32   = 64'sd4294967296;

  logic              clk;
  logic              rst_n;
  logic [PC_W-1:0]   lookup_pc;
  logic              lookup_taken;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_ctrl;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [PC_W-1:0]   in_pc;
  logic [PC_W-1:0]   in_target;
  logic              in_pred_taken;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic              out_mispredict;
  logic [PC_W-1:0]   out_redirect_pc;
  logic [CNT_W-1:0]  perf_branches;
  logic [CNT_W-1:0]  perf_mispred;

  branch_resolve_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_a(in_a),
    .in_b(in_b), .in_pc(in_pc), .in_target(in_target), .in_pred_taken(in_pred_taken),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        taken;
    bit        mis;
    bit [31:0] redir;
    bit        br;
    int        idx;
  } exp_t;

  exp_t q[$];
  int   bht_m [BHT_DEPTH];
  int   nbr_m, nmis_m;
  int   checks, errors;
  bit   armed, just_reset, rand_mode;

  function automatic exp_t ref_eval(input bit [3:0] c, input bit [31:0] a, input bit [31:0] b,
                                    input bit [31:0] pc, input bit [31:0] tgt, input bit pred);
    longint ua, ub, sa, sb;
    exp_t   e;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= P32 / 2) ? ua - P32 : ua;
    sb = (ub >= P32 / 2) ? ub - P32 : ub;
    e.br    = 1'b1;
    e.taken = 1'b0;
    case (c)
      4'd1: e.taken = (ua == ub);
      4'd2: e.taken = (ua != ub);
      4'd3: e.taken = (sa <= 0);
      4'd4: e.taken = (sa > 0);
      4'd5: e.taken = (sa < sb);
      4'd6: e.taken = (sa >= 0);
      4'd7: e.taken = (ua < ub);
      4'd8: e.taken = (ua >= ub);
      default: e.br = 1'b0;
    endcase
    e.mis   = e.br && (e.taken != pred);
    e.redir = e.taken ? tgt : 32'((longint'(pc) + 4) % P32);
    e.idx   = int'((longint'(pc) / 4) % BHT_DEPTH);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compare first, then advance the model for the coming edge.
  always @(negedge clk) begin
    exp_t e;
    bit   rdy_m;
    int   li;
    if (armed) begin
      li = int'((longint'(lookup_pc) / 4) % BHT_DEPTH);
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready));
      chk("perf_branches", 64'(perf_branches), 64'(nbr_m));
      chk("perf_mispred", 64'(perf_mispred), 64'(nmis_m));
      chk("lookup_taken", 64'(lookup_taken), 64'(bht_m[li] >= 2));
      if (q.size() != 0) begin
        chk("out_taken", 64'(out_taken), 64'(q[0].taken));
        chk("out_mispredict", 64'(out_mispredict), 64'(q[0].mis));
        chk("out_redirect_pc", 64'(out_redirect_pc), 64'(q[0].redir));
      end else if (just_reset) begin
        chk("reset out_taken", 64'(out_taken), 64'(0));
        chk("reset out_mispredict", 64'(out_mispredict), 64'(0));
        chk("reset out_redirect_pc", 64'(out_redirect_pc), 64'(0));
      end
    end
    if (rst_n !== 1'b1) begin
      q.delete();
      foreach (bht_m[i]) bht_m[i] = 1;
      nbr_m      = 0;
      nmis_m     = 0;
      armed      = 1'b1;
      just_reset = 1'b1;
    end else if (armed) begin
      rdy_m = (q.size() == 0) || out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) begin
          e = q.pop_front();
          if (e.br) begin
            if (e.taken) bht_m[e.idx] = (bht_m[e.idx] < 3) ? bht_m[e.idx] + 1 : 3;
            else         bht_m[e.idx] = (bht_m[e.idx] > 0) ? bht_m[e.idx] - 1 : 0;
            nbr_m = (nbr_m < CNT_MAX) ? nbr_m + 1 : nbr_m;
            if (e.mis) nmis_m = (nmis_m < CNT_MAX) ? nmis_m + 1 : nmis_m;
          end
        end
        if (in_valid && rdy_m) begin
          q.push_back(ref_eval(in_ctrl, in_a, in_b, in_pc, in_target, in_pred_taken));
          just_reset = 1'b0;
        end
      end
    end
  end

  function automatic bit [31:0] pick_pc();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'hFFFF_FFFC;
      default: return 32'h0000_0400 + 32'($urandom_range(0, 7)) * 4;
    endcase
  endfunction

  function automatic bit [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 8)) - 32'd4;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      lookup_pc = pick_pc();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one op and holds it until accepted (bounded).
  task automatic issue(input bit [3:0] c, input bit [31:0] a, input bit [31:0] b,
                       input bit [31:0] pc, input bit [31:0] tgt, input bit pred);
    bit done;
    done          = 1'b0;
    in_ctrl       = c;
    in_a          = a;
    in_b          = b;
    in_pc         = pc;
    in_target     = tgt;
    in_pred_taken = pred;
    in_valid      = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = in_ready && !flush;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; armed = 1'b0; just_reset = 1'b0; rand_mode = 1'b0;
    rst_n = 1'b0; lookup_pc = '0; in_valid = 1'b0; in_ctrl = '0; in_a = '0; in_b = '0;
    in_pc = '0; in_target = '0; in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
    do_reset();

    // Beq hit with not-taken prediction, then the trained entry predicts taken.
    lookup_pc = 32'h40;
    tick();
    issue(4'd1, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0);
    idle(3);

    // Signed versus unsigned compares and zero tests.
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h44, 32'h200, 1'b0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'h48, 32'h200, 1'b1);
    issue(4'd3, 32'd0, 32'd9, 32'h4C, 32'h300, 1'b1);
    issue(4'd4, 32'd0, 32'd9, 32'h50, 32'h300, 1'b1);
    idle(2);

    // Backpressure with a second op waiting.
    do_reset();
    out_ready = 1'b0;
    issue(4'd2, 32'd1, 32'd2, 32'h40, 32'h500, 1'b0);
    in_ctrl = 4'd8; in_a = 32'd3; in_b = 32'd3; in_pc = 32'h60; in_target = 32'h600;
    in_pred_taken = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    idle(2);

    // Flush with a pending result and a same-cycle incoming op.
    out_ready = 1'b0;
    issue(4'd1, 32'd7, 32'd7, 32'h40, 32'h700, 1'b0);
    in_ctrl = 4'd1; in_pc = 32'h40; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(2);

    // Saturation of the history entry and of the branch counter.
    do_reset();
    lookup_pc = 32'h80;
    for (int i = 0; i < 5; i++) issue(4'd1, 32'd7, 32'd7, 32'h80, 32'h800, 1'b1);
    idle(2);

    // Reserved code, then reset in the middle of a stall.
    issue(4'd12, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h900, 1'b1);
    idle(2);
    out_ready = 1'b0;
    issue(4'd1, 32'd1, 32'd1, 32'h84, 32'hA00, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    idle(3);

    // Random traffic with random backpressure, flushes and occasional resets.
    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      bit [31:0] a, b;
      bit [3:0]  c;
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        a = pick_val();
        b = ($urandom_range(0, 2) == 0) ? a : pick_val();
        c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        issue(c, a, b, pick_pc(), $urandom, 1'($urandom_range(0, 1)));
      end
    end
    rand_mode = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
